// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write bus of the boot loader.
// Handshake: a byte moves on a rising edge where byte_valid_i & byte_ready_o are both 1;
// the source holds byte_data_i stable while byte_valid_i is 1 and ready is 0.
interface program_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;

  modport master (
    output byte_valid_i, byte_data_i,
    input  byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  byte_valid_i, byte_data_i,
    output byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: length header + big-endian words into program memory, then releases the core.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int          MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              reset,
  program_loader_if.slave   bus,
  output logic              cpu_hold_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [2:0]        dbg_state_o
);
  localparam int         CW      = $clog2(MEMORY_DEPTH + 1);
  localparam logic [15:0] MAX_LEN = 16'(MEMORY_DEPTH);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam logic   AFTER_CHECK = 1'b1;
  localparam state_t AFTER_LAST  = S_CHECK;
`else
  localparam logic   AFTER_CHECK = 1'b0;
  localparam state_t AFTER_LAST  = S_DONE;
`endif

  state_t          state_q;
  logic [7:0]      len_hi_q;
  logic [CW-1:0]   n_q;
  logic [CW-1:0]   word_cnt_q;
  logic [1:0]      byte_idx_q;
  logic [23:0]     shift_q;
  logic            ready_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            hold_q;
  logic            done_q;
  logic            err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  logic            xfer;
  logic [15:0]     len_w;
  logic [CW-1:0]   cnt_inc;
  logic [31:0]     word_addr;

  assign xfer      = bus.byte_valid_i & ready_q;
  assign len_w     = {len_hi_q, bus.byte_data_i};
  assign cnt_inc   = word_cnt_q + CW'(1);
  assign word_addr = BASE_ADDR + {{(30-CW){1'b0}}, word_cnt_q, 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_LEN_HI;
      len_hi_q   <= 8'h00;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= 2'd0;
      shift_q    <= 24'h0;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'h0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_LEN_HI: if (xfer) begin
          len_hi_q <= bus.byte_data_i;
          state_q  <= S_LEN_LO;
        end
        S_LEN_LO: if (xfer) begin
          if (len_w == 16'd0) begin
            state_q <= AFTER_LAST;
            ready_q <= AFTER_CHECK;
            hold_q  <= AFTER_CHECK;
            done_q  <= !AFTER_CHECK;
          end else if (len_w > MAX_LEN) begin
            state_q <= S_ERROR;
            ready_q <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            n_q     <= len_w[CW-1:0];
            state_q <= S_DATA;
          end
        end
        S_DATA: if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          csum_q <= csum_q ^ bus.byte_data_i;
`endif
          if (byte_idx_q == 2'd3) begin
            wdata_q    <= {shift_q, bus.byte_data_i};
            addr_q     <= word_addr;
            we_q       <= 1'b1;
            ready_q    <= 1'b0;
            byte_idx_q <= 2'd0;
            state_q    <= S_WRITE;
          end else begin
            shift_q    <= {shift_q[15:0], bus.byte_data_i};
            byte_idx_q <= byte_idx_q + 2'd1;
          end
        end
        // The write strobe is already high this cycle; only bookkeeping happens here.
        S_WRITE: begin
          word_cnt_q <= cnt_inc;
          if (cnt_inc == n_q) begin
            state_q <= AFTER_LAST;
            ready_q <= AFTER_CHECK;
            hold_q  <= AFTER_CHECK;
            done_q  <= !AFTER_CHECK;
          end else begin
            state_q <= S_DATA;
            ready_q <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: if (xfer) begin
          ready_q <= 1'b0;
          if (bus.byte_data_i == csum_q) begin
            state_q <= S_DONE;
            hold_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
          end
        end
`endif
        default: state_q <= state_q;
      endcase
    end
  end

  assign bus.byte_ready_o = ready_q & reset;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign cpu_hold_o       = hold_q;
  assign load_done_o      = done_q;
  assign load_err_o       = err_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: vector table of whole loads plus hand-written
// sequences for reset, mid-load reset, stalls during WRITE and the maximum length.
module tb_program_loader;
  localparam logic [31:0] BASE = 32'h0040_0000;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic [2:0] dbg_state;

  program_loader_if bus ();

  program_loader #(.MEMORY_DEPTH(32), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .cpu_hold_o  (cpu_hold),
    .load_done_o (load_done),
    .load_err_o  (load_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];

  always @(negedge clk)
    if (bus.mem_we_o === 1'b1) obs_q.push_back({bus.mem_addr_o, bus.mem_wdata_o});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_writes(input string name);
    check({name, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({name, "_wr"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
  endtask

  // Starts and ends on a falling edge; waits (bounded) for ready.
  task automatic send_byte(input logic [7:0] b);
    int budget = 20;
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    while (bus.byte_ready_o !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: byte 0x%0h not accepted, ready=%b", b, bus.byte_ready_o);
    end else begin
      @(negedge clk);
    end
    bus.byte_valid_i = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [127:0] raw;     // stream bytes, right-aligned, first byte most significant
    int          n;
    bit          use_trl;
    logic [7:0]  trl;
    int          nwr;
    logic [31:0] a0, d0, a1, d1;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [127:0] raw, int n, bit use_trl,
                              logic [7:0] trl, int nwr, logic [31:0] a0, logic [31:0] d0,
                              logic [31:0] a1, logic [31:0] d1, logic done, logic err);
    vec_t v;
    v.name = name; v.raw = raw; v.n = n; v.use_trl = use_trl; v.trl = trl;
    v.nwr = nwr; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.done = done; v.err = err;
    return v;
  endfunction

  initial begin
    logic [7:0] bb[128];
    logic [7:0] x;

    vecs.push_back(mk("two_words", 128'h0002_2008_0005_0109_5020, 10, 1'b1, 8'h55,
                      2, BASE, 32'h2008_0005, BASE + 32'd4, 32'h0109_5020, 1'b1, 1'b0));
    vecs.push_back(mk("len_33", 128'h0021, 2, 1'b0, 8'h00,
                      0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1));
    vecs.push_back(mk("len_256", 128'h0100, 2, 1'b0, 8'h00,
                      0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1));
    vecs.push_back(mk("len_0", 128'h0000, 2, 1'b1, 8'h00,
                      0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk("one_word", 128'h0001_1234_5678, 6, 1'b1, 8'h08,
                      1, BASE, 32'h1234_5678, 32'h0, 32'h0, 1'b1, 1'b0));
`ifdef LOADER_CHECKSUM_EN
    vecs.push_back(mk("bad_csum", 128'h0001_1234_5678, 6, 1'b1, 8'h09,
                      1, BASE, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b1));
`endif

    // ---- reset state ----
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready_low", 64'(bus.byte_ready_o), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready",  64'(bus.byte_ready_o), 64'd1);
    check("rst_hold",   64'(cpu_hold), 64'd1);
    check("rst_we",     64'(bus.mem_we_o), 64'd0);
    check("rst_addr",   64'(bus.mem_addr_o), 64'(BASE));
    check("rst_wdata",  64'(bus.mem_wdata_o), 64'd0);
    check("rst_done",   64'(load_done), 64'd0);
    check("rst_err",    64'(load_err), 64'd0);
    check("rst_state",  64'(dbg_state), 64'd0);

    // ---- table-driven loads ----
    foreach (vecs[k]) begin
      do_reset();
      if (vecs[k].nwr > 0) exp_q.push_back({vecs[k].a0, vecs[k].d0});
      if (vecs[k].nwr > 1) exp_q.push_back({vecs[k].a1, vecs[k].d1});
      for (int i = 0; i < vecs[k].n; i++)
        send_byte(vecs[k].raw[8*(vecs[k].n-1-i) +: 8]);
      if (CS_EN && vecs[k].use_trl) send_byte(vecs[k].trl);
      repeat (2) @(negedge clk);
      check({vecs[k].name, "_done"},  64'(load_done), 64'(vecs[k].done));
      check({vecs[k].name, "_err"},   64'(load_err), 64'(vecs[k].err));
      check({vecs[k].name, "_hold"},  64'(cpu_hold), 64'(!vecs[k].done));
      check({vecs[k].name, "_ready"}, 64'(bus.byte_ready_o), 64'd0);
      check_writes(vecs[k].name);
    end

    // ---- error is terminal: ready stays low with valid held ----
    do_reset();
    send_byte(8'h00);
    send_byte(8'h21);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = 8'h20;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("err_ready_stuck", 64'(bus.byte_ready_o), 64'd0);
    end
    bus.byte_valid_i = 1'b0;
    check("err_sticky", 64'(load_err), 64'd1);
    check("err_no_done", 64'(load_done), 64'd0);
    check("err_hold", 64'(cpu_hold), 64'd1);
    check_writes("err_stuck");

    // ---- empty load timing ----
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    check("len0_done_2cyc", 64'(load_done), 64'(!CS_EN));
    check("len0_ready", 64'(bus.byte_ready_o), 64'(CS_EN));
    check_writes("len0_timing");

    // ---- reset mid-load, then a full single-word load with a stall during WRITE ----
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_addr",  64'(bus.mem_addr_o), 64'(BASE));
    check("midrst_wdata", 64'(bus.mem_wdata_o), 64'd0);
    check("midrst_hold",  64'(cpu_hold), 64'd1);
    check("midrst_state", 64'(dbg_state), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    obs_q.delete();
    exp_q.push_back({BASE, 32'hAABB_CCDD});
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    // now in the WRITE cycle: hold the next byte on the bus
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = CS_EN ? 8'h00 : 8'hEE;
    check("write_ready_low", 64'(bus.byte_ready_o), 64'd0);
    check("write_we", 64'(bus.mem_we_o), 64'd1);
    repeat (2) @(negedge clk);
    bus.byte_valid_i = 1'b0;
    check("stall_done", 64'(load_done), 64'd1);
    check("stall_err",  64'(load_err), 64'd0);
    check("stall_hold", 64'(cpu_hold), 64'd0);
    check_writes("stall");

    // ---- maximum length load (N == MEMORY_DEPTH) ----
    do_reset();
    x = 8'h00;
    for (int k = 0; k < 128; k++) begin
      bb[k] = 8'(k * 7 + 3);
      x = x ^ bb[k];
    end
    for (int w = 0; w < 32; w++)
      exp_q.push_back({BASE + 32'(4 * w), bb[4*w], bb[4*w+1], bb[4*w+2], bb[4*w+3]});
    send_byte(8'h00);
    send_byte(8'h20);
    for (int k = 0; k < 128; k++) send_byte(bb[k]);
    if (CS_EN) send_byte(x);
    repeat (2) @(negedge clk);
    check("max_done", 64'(load_done), 64'd1);
    check("max_err",  64'(load_err), 64'd0);
    check_writes("max_len");

    // ---- input ignored after done ----
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_ready_low", 64'(bus.byte_ready_o), 64'd0);
    end
    bus.byte_valid_i = 1'b0;
    check("done_sticky", 64'(load_done), 64'd1);
    check_writes("after_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
